// File: rtl/div_pkg.sv
// div_pkg: state encoding, default width and job record shared by the divider job sequencer
package div_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  typedef struct packed {
    logic [DEF_WIDTH-1:0] dividend;
    logic [DEF_WIDTH-1:0] divisor;
  } job_t;
endpackage

// File: rtl/div_job_sequencer_if.sv
// div_job_sequencer_if: job input, divider handshake, result and status signals (slave = sequencer, master = environment)
interface div_job_sequencer_if import div_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic job_valid, job_ready;
  logic [WIDTH-1:0] job_dividend, job_divisor;
  logic go, done, error;
  logic [WIDTH-1:0] dividend, divisor, quotient, remainder;
  logic [3:0] n;
  logic res_valid, res_ready, res_error, res_timeout;
  logic [WIDTH-1:0] res_quotient, res_remainder;
  logic [7:0] jobs_done;
  modport slave (
    input job_valid, job_dividend, job_divisor, done, quotient, remainder, error, res_ready,
    output job_ready, go, dividend, divisor, n, res_valid, res_quotient, res_remainder, res_error, res_timeout, jobs_done
  );
  modport master (
    output job_valid, job_dividend, job_divisor, done, quotient, remainder, error, res_ready,
    input job_ready, go, dividend, divisor, n, res_valid, res_quotient, res_remainder, res_error, res_timeout, jobs_done
  );
endinterface

// File: rtl/div_job_fifo.sv
// div_job_fifo: power-of-two job FIFO (push/pop/full/empty/head), pointers carry an extra wrap bit
module div_job_fifo import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [2*WIDTH-1:0] data,
  output logic               full,
  output logic               empty,
  output logic [2*WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic do_push, do_pop;
  assign empty = wr == rd;
  assign full = wr == {~rd[AW], rd[AW-1:0]};
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd[AW-1:0]];
  always_ff @(posedge clk)
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr[AW-1:0]] <= data;
endmodule

// File: rtl/div_job_sequencer.sv
// div_job_sequencer: queues divide jobs and issues them one at a time to an external divider (clk, rst, bus: job/divider/result/status); DIV_SEQ_TIMEOUT_EN adds a RUN watchdog
module div_job_sequencer import div_pkg::*; #(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input logic clk,
  input logic rst,
  div_job_sequencer_if.slave bus
);
`ifdef DIV_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_nx;
  logic full, empty, start, fin, tmo;
  logic [2*WIDTH-1:0] head;
  logic [TW-1:0] tmr;
  div_job_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(bus.job_valid && !full),
    .pop(fin),
    .data({bus.job_dividend, bus.job_divisor}),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (fin ? GAP : RUN) : IDLE;
  always_comb begin
    start = state == IDLE && !empty && (!bus.res_valid || bus.res_ready);
    tmo = TMO_EN && state == RUN && !bus.done && tmr == TW'(TIMEOUT_CYCLES - 1);
    fin = state == RUN && (bus.done || tmo);
    bus.go = state == RUN;
    bus.job_ready = !full;
    bus.n = 4'(WIDTH);
  end
  always_ff @(posedge clk)
    tmr <= (rst || state != RUN) ? '0 : tmr + 1'b1;
  always_ff @(posedge clk)
    if (rst) begin
      bus.dividend <= '0;
      bus.divisor <= '0;
      bus.res_valid <= 1'b0;
      bus.res_quotient <= '0;
      bus.res_remainder <= '0;
      bus.res_error <= 1'b0;
      bus.res_timeout <= 1'b0;
      bus.jobs_done <= '0;
    end else begin
      if (start) {bus.dividend, bus.divisor} <= head;
      if (fin) begin
        bus.res_quotient <= tmo ? '0 : bus.quotient;
        bus.res_remainder <= tmo ? '0 : bus.remainder;
        bus.res_error <= tmo || bus.error;
        bus.res_timeout <= tmo;
        bus.jobs_done <= bus.jobs_done + 8'd1;
      end
      bus.res_valid <= fin || (bus.res_valid && !bus.res_ready);
    end
endmodule

// File: tb/tb_div_job_sequencer.sv
// tb_div_job_sequencer: directed and randomized checks of div_job_sequencer against a job-level queue model
module tb_div_job_sequencer;
  import div_pkg::*;
  localparam int W = 4, D = 4, TC = 32;
`ifdef DIV_SEQ_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  div_job_sequencer_if #(.WIDTH(W)) bus ();
  div_job_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT_CYCLES(TC)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic jv = 1'b0;
  logic [W-1:0] jdd = '0, jdv = '0;
  logic rr_fixed = 1'b1, rr_rand = 1'b1, rand_rr = 1'b0, done_off = 1'b0;
  int lat = 6, dcnt = 0;
  assign bus.job_valid = jv;
  assign bus.job_dividend = jdd;
  assign bus.job_divisor = jdv;
  assign bus.res_ready = rand_rr ? rr_rand : rr_fixed;
  always @(posedge clk) dcnt <= bus.go ? dcnt + 1 : 0;
  always @(posedge clk) rr_rand <= 1'($urandom_range(0, 1));
  assign bus.done = bus.go && !done_off && dcnt == lat - 1;
  assign bus.quotient = bus.divisor == '0 ? '0 : bus.dividend / bus.divisor;
  assign bus.remainder = bus.divisor == '0 ? '0 : bus.dividend % bus.divisor;
  assign bus.error = bus.divisor == '0;
  job_t q[$];
  bit run, gap, ev, ee, et, cap, started;
  int rc, sz, checks = 0, failures = 0;
  logic [W-1:0] eq, er, ldd, ldv;
  logic [7:0] jd;
  logic [W-1:0] got[$];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  initial forever begin
    @(posedge clk);
    if (rst) begin
      q.delete();
      {run, gap, ev, ee, et} = '0;
      rc = 0;
      eq = '0; er = '0; ldd = '0; ldv = '0; jd = '0;
    end else begin
      sz = q.size();
      cap = 1'b0;
      if (run) begin
        if (!done_off && rc == lat - 1) begin
          cap = 1'b1; et = 1'b0;
          ee = q[0].divisor == '0;
          eq = ee ? '0 : q[0].dividend / q[0].divisor;
          er = ee ? '0 : q[0].dividend % q[0].divisor;
        end else if (TMO && rc == TC - 1) begin
          cap = 1'b1; et = 1'b1; ee = 1'b1; eq = '0; er = '0;
        end else rc++;
        if (cap) begin
          run = 1'b0; gap = 1'b1; jd = jd + 8'd1;
          void'(q.pop_front());
        end
      end else if (gap) gap = 1'b0;
      else if (sz > 0 && (!ev || bus.res_ready)) begin
        run = 1'b1; rc = 0; ldd = q[0].dividend; ldv = q[0].divisor;
      end
      if (cap) ev = 1'b1;
      else if (ev && bus.res_ready) ev = 1'b0;
      if (jv && sz < D) q.push_back('{jdd, jdv});
    end
  end
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("job_ready", bus.job_ready, q.size() < D);
      chk("go", bus.go, run);
      chk("dividend", bus.dividend, ldd);
      chk("divisor", bus.divisor, ldv);
      chk("res_valid", bus.res_valid, ev);
      chk("res_quotient", bus.res_quotient, eq);
      chk("res_remainder", bus.res_remainder, er);
      chk("res_error", bus.res_error, ee);
      chk("res_timeout", bus.res_timeout, et);
      chk("jobs_done", bus.jobs_done, jd);
      chk("n", bus.n, W);
      if (!rst && bus.res_valid && bus.res_ready) got.push_back(bus.res_quotient);
    end
  end
  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 1'b0;
    jv = 1'b1; jdd = a; jdv = b;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.job_ready;
      @(posedge clk);
      #2;
    end
    jv = 1'b0;
    if (!ok) chk("push_accept", 0, 1);
  endtask
  task automatic wait_valid(output int gc);
    bit seen = 1'b0;
    gc = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.go) gc++;
      seen = bus.res_valid;
    end
    if (!seen) chk("res_valid_wait", 0, 1);
  endtask
  task automatic drain(input int limit);
    bit idle = 1'b0;
    for (int i = 0; i < limit && !idle; i++) begin
      step(1);
      idle = q.size() == 0 && !run && !gap && !ev;
    end
    if (!idle) chk("drain", 0, 1);
  endtask
  initial begin
    int gc, n0;
    logic [W-1:0] exp_q [5];
    @(posedge clk);
    started = 1'b1;
    #2;
    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_go", bus.go, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_jobs_done", bus.jobs_done, 0);
    chk("rst_job_ready", bus.job_ready, 1);
    chk("rst_dividend", bus.dividend, 0);
    step(1);
    push(4'd10, 4'd3);
    wait_valid(gc);
    chk("div10_3_go_cycles", gc, 6);
    chk("div10_3_q", bus.res_quotient, 3);
    chk("div10_3_r", bus.res_remainder, 1);
    chk("div10_3_err", bus.res_error, 0);
    chk("div10_3_jobs_done", bus.jobs_done, 1);
    step(3);
    push(4'd7, 4'd0);
    wait_valid(gc);
    chk("div7_0_err", bus.res_error, 1);
    chk("div7_0_tmo", bus.res_timeout, 0);
    step(3);
    @(negedge clk);
    chk("div7_0_idle_go", bus.go, 0);
    step(1);
    rr_fixed = 1'b0;
    n0 = got.size();
    exp_q = '{4'd4, 4'd2, 4'd3, 4'd1, 4'd2};
    push(4'd9, 4'd2);
    push(4'd8, 4'd3);
    push(4'd15, 4'd4);
    push(4'd6, 4'd6);
    @(negedge clk);
    chk("full_job_ready", bus.job_ready, 0);
    step(1);
    jv = 1'b1; jdd = 4'd11; jdv = 4'd5;
    step(30);
    jv = 1'b0;
    @(negedge clk);
    chk("stall_jobs_done", bus.jobs_done, 3);
    chk("stall_go", bus.go, 0);
    chk("stall_job_ready", bus.job_ready, 0);
    step(1);
    rr_fixed = 1'b1;
    drain(300);
    chk("order_count", got.size() - n0, 5);
    for (int i = 0; i < 5; i++)
      if (n0 + i < got.size()) chk("order_q", got[n0 + i], exp_q[i]);
    chk("order_jobs_done", bus.jobs_done, 7);
    push(4'd12, 4'd5);
    push(4'd3, 4'd1);
    step(2);
    @(negedge clk);
    chk("pre_rst_go", bus.go, 1);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_rst_go", bus.go, 0);
    chk("midrun_rst_res_valid", bus.res_valid, 0);
    chk("midrun_rst_jobs_done", bus.jobs_done, 0);
    chk("midrun_rst_job_ready", bus.job_ready, 1);
    step(10);
    @(negedge clk);
    chk("midrun_rst_no_issue", bus.go, 0);
    chk("midrun_rst_no_result", bus.jobs_done, 0);
    step(1);
    lat = $urandom_range(1, 4);
    rand_rr = 1'b1;
    n0 = got.size();
    for (int i = 0; i < 256; i++) begin
      push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      step($urandom_range(0, 2));
    end
    rand_rr = 1'b0;
    rr_fixed = 1'b1;
    drain(3000);
    chk("wrap_jobs_done", bus.jobs_done, 0);
    chk("wrap_result_count", got.size() - n0, 256);
`ifdef DIV_SEQ_TIMEOUT_EN
    done_off = 1'b1;
    push(4'd13, 4'd2);
    wait_valid(gc);
    chk("tmo_go_cycles", gc, 32);
    chk("tmo_err", bus.res_error, 1);
    chk("tmo_flag", bus.res_timeout, 1);
    chk("tmo_q", bus.res_quotient, 0);
    step(1);
    done_off = 1'b0;
    lat = 2;
    push(4'd6, 4'd2);
    wait_valid(gc);
    chk("post_tmo_q", bus.res_quotient, 3);
    chk("post_tmo_flag", bus.res_timeout, 0);
    step(1);
`endif
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end
endmodule
